// File: rtl/bmp_stream_writer.sv
// bmp_stream_writer: turns a stream of RGB888 pixels into the byte stream
// of a complete uncompressed 24-bpp BMP file (54-byte header + padded rows).
module bmp_stream_writer #(
  parameter int PIX_W = 24,
  parameter int DIM_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [DIM_W-1:0] img_width_i,
  input  logic [DIM_W-1:0] img_height_i,
  input  logic [PIX_W-1:0] pix_data_i,
  input  logic             pix_valid_i,
  output logic             pix_ready_o,
  output logic [7:0]       out_data_o,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic             busy_o,
  output logic             done_o
);

  typedef enum logic [2:0] {S_IDLE, S_HEADER, S_PIXEL, S_PAD, S_DONE} state_e;

  state_e             state_q, state_d;
  logic [5:0]         idx_q, idx_d;        // next header byte to load
  logic [DIM_W-1:0]   col_q, col_d;
  logic [DIM_W-1:0]   row_q, row_d;
  logic [1:0]         phase_q, phase_d;    // 0:B 1:G 2:R byte of current pixel
  logic [1:0]         padc_q, padc_d;
  logic [PIX_W-1:0]   pix_q, pix_d;
  logic [DIM_W-1:0]   w_q, w_d, h_q, h_d;
  logic [1:0]         pad_q, pad_d;
  logic [31:0]        img_size_q, img_size_d;
  logic [31:0]        file_size_q, file_size_d;
  logic [7:0]         obyte_q, obyte_d;
  logic               ovld_q, ovld_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  // Output slot can take a new byte when empty or being drained this cycle.
  logic free;
  assign free = !ovld_q || out_ready_i;

  // Derived sizes computed straight from the inputs at start.
  logic [31:0] row_bytes_c, img_size_c;
  assign row_bytes_c = 32'(img_width_i) * 32'd3 + 32'(img_width_i[1:0]);
  assign img_size_c  = row_bytes_c * 32'(img_height_i);

  // Header byte lookup: pick the little-endian field containing idx_q.
  logic [31:0] hdr_fld;
  logic [5:0]  hdr_base;
  logic [1:0]  hdr_sh;
  logic [7:0]  hdr_byte;
  always_comb begin
    hdr_fld  = 32'd0;
    hdr_base = idx_q;
    case (idx_q) inside
      [6'd0:6'd1]:   begin hdr_fld = 32'h0000_4D42;  hdr_base = 6'd0;  end
      [6'd2:6'd5]:   begin hdr_fld = file_size_q;    hdr_base = 6'd2;  end
      [6'd10:6'd13]: begin hdr_fld = 32'd54;         hdr_base = 6'd10; end
      [6'd14:6'd17]: begin hdr_fld = 32'd40;         hdr_base = 6'd14; end
      [6'd18:6'd21]: begin hdr_fld = 32'(w_q);       hdr_base = 6'd18; end
      [6'd22:6'd25]: begin hdr_fld = 32'(h_q);       hdr_base = 6'd22; end
      [6'd26:6'd27]: begin hdr_fld = 32'd1;          hdr_base = 6'd26; end
      [6'd28:6'd29]: begin hdr_fld = 32'd24;         hdr_base = 6'd28; end
      [6'd34:6'd37]: begin hdr_fld = img_size_q;     hdr_base = 6'd34; end
      [6'd38:6'd41]: begin hdr_fld = 32'd2835;       hdr_base = 6'd38; end
      [6'd42:6'd45]: begin hdr_fld = 32'd2835;       hdr_base = 6'd42; end
      default:       begin hdr_fld = 32'd0;          hdr_base = idx_q; end
    endcase
    hdr_sh   = 2'(idx_q - hdr_base);
    hdr_byte = 8'(hdr_fld >> {hdr_sh, 3'b000});
  end

  // Next-state and output-byte selection; a byte is loaded whenever the slot is free.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    col_d       = col_q;
    row_d       = row_q;
    phase_d     = phase_q;
    padc_d      = padc_q;
    pix_d       = pix_q;
    w_d         = w_q;
    h_d         = h_q;
    pad_d       = pad_q;
    img_size_d  = img_size_q;
    file_size_d = file_size_q;
    obyte_d     = obyte_q;
    ovld_d      = ovld_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    pix_ready_o = 1'b0;
    case (state_q)
      S_IDLE: if (start_i) begin
        w_d         = img_width_i;
        h_d         = img_height_i;
        pad_d       = img_width_i[1:0];
        img_size_d  = img_size_c;
        file_size_d = 32'd54 + img_size_c;
        col_d       = '0;
        row_d       = '0;
        phase_d     = 2'd0;
        padc_d      = 2'd0;
        idx_d       = 6'd1;
        obyte_d     = 8'h42;
        ovld_d      = 1'b1;
        busy_d      = 1'b1;
        state_d     = S_HEADER;
      end
      S_HEADER: if (free) begin
        obyte_d = hdr_byte;
        ovld_d  = 1'b1;
        idx_d   = idx_q + 6'd1;
        // Leave as soon as the last header byte is loaded so the first
        // pixel can be taken in the cycle that byte drains.
        if (idx_q == 6'd53)
          state_d = (w_q != '0 && h_q != '0) ? S_PIXEL : S_DONE;
      end
      S_PIXEL: if (free) begin
        case (phase_q)
          2'd0: begin
            pix_ready_o = 1'b1;
            if (pix_valid_i) begin
              pix_d   = pix_data_i;
              obyte_d = pix_data_i[7:0];
              ovld_d  = 1'b1;
              phase_d = 2'd1;
            end else begin
              ovld_d  = 1'b0;
            end
          end
          2'd1: begin
            obyte_d = pix_q[15:8];
            ovld_d  = 1'b1;
            phase_d = 2'd2;
          end
          default: begin
            obyte_d = pix_q[23:16];
            ovld_d  = 1'b1;
            phase_d = 2'd0;
            if (col_q == w_q - 1'b1) begin
              col_d = '0;
              if (pad_q != 2'd0) begin
                padc_d  = 2'd0;
                state_d = S_PAD;
              end else begin
                row_d = row_q + 1'b1;
                if (row_q == h_q - 1'b1) state_d = S_DONE;
              end
            end else begin
              col_d = col_q + 1'b1;
            end
          end
        endcase
      end
      S_PAD: if (free) begin
        obyte_d = 8'h00;
        ovld_d  = 1'b1;
        padc_d  = padc_q + 2'd1;
        if (padc_q == pad_q - 2'd1) begin
          padc_d  = 2'd0;
          row_d   = row_q + 1'b1;
          state_d = (row_q == h_q - 1'b1) ? S_DONE : S_PIXEL;
        end
      end
      S_DONE: if (free) begin
        // Final byte has drained: pulse done and release busy together.
        ovld_d  = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      col_q       <= '0;
      row_q       <= '0;
      phase_q     <= '0;
      padc_q      <= '0;
      pix_q       <= '0;
      w_q         <= '0;
      h_q         <= '0;
      pad_q       <= '0;
      img_size_q  <= '0;
      file_size_q <= '0;
      obyte_q     <= '0;
      ovld_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      col_q       <= col_d;
      row_q       <= row_d;
      phase_q     <= phase_d;
      padc_q      <= padc_d;
      pix_q       <= pix_d;
      w_q         <= w_d;
      h_q         <= h_d;
      pad_q       <= pad_d;
      img_size_q  <= img_size_d;
      file_size_q <= file_size_d;
      obyte_q     <= obyte_d;
      ovld_q      <= ovld_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign out_data_o  = obyte_q;
  assign out_valid_o = ovld_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;

endmodule
